// File: rtl/simon_inverse_keyexpansion.sv
// Reverse SIMON key schedule: regenerates k[T-1]..k[0] from the last M round keys,
// emitting one round key per valid/ready handshake to the decryption datapath.
module simon_inverse_keyexpansion #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter logic [61:0] Z = 62'h19C3522FB386A45F,
  localparam int IW = $clog2(T)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic [N-1:0]  key_last [M-1:0],
  output logic [N-1:0]  key_out,
  output logic [IW-1:0] key_idx,
  output logic          key_valid,
  input  logic          key_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [5:0]    ZSTART = 6'((T - M - 1) % 62);
  localparam logic [IW-1:0] LASTIDX = IW'(T - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [N-1:0]  r_win [M];
  logic [IW-1:0] r_idx;
  logic [5:0]    r_zptr;
  logic          w_accept;
  logic          w_lastKey;
  logic          w_load;
  logic [N-1:0]  w_tmp;
  logic [N-1:0]  w_mix;
  logic [N-1:0]  w_knew;

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  assign w_accept  = (r_state == EMIT) && key_ready;
  assign w_lastKey = (r_idx == '0);
  assign w_load    = (r_state != EMIT) && start;

  // Undo one forward step: recover k[i-1] from k[i..i+M-1].
  always_comb begin
    w_tmp = ror(r_win[M-2], 3);
    if (M == 4) w_tmp = w_tmp ^ r_win[0];
    w_mix  = w_tmp ^ ror(w_tmp, 1);
    w_knew = ~(r_win[M-1] ^ w_mix ^ N'(Z[r_zptr]) ^ N'(3));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_nextState = EMIT;
      EMIT:       if (w_accept && w_lastKey) w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    key_valid = (r_state == EMIT);
    busy      = (r_state == EMIT);
    done      = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int j = 0; j < M; j++) r_win[j] <= '0;
      r_idx  <= '0;
      r_zptr <= '0;
    end else if (w_load) begin
      for (int j = 0; j < M; j++) r_win[j] <= key_last[j];
      r_idx  <= LASTIDX;
      r_zptr <= ZSTART;
    end else if (w_accept && !w_lastKey) begin
      for (int j = M - 1; j >= 1; j--) r_win[j] <= r_win[j-1];
      r_win[0] <= w_knew;
      r_idx    <= r_idx - 1'b1;
      r_zptr   <= (r_zptr == 6'd0) ? 6'd61 : r_zptr - 6'd1;
    end
  end

  assign key_out = r_win[M-1];
  assign key_idx = r_idx;

endmodule

// File: tb/tb_simon_inverse_keyexpansion.sv
// Directed bench for the reverse SIMON key schedule; expected keys come from a
// forward-direction schedule model built inside the bench.
module tb_simon_inverse_keyexpansion;

  localparam logic [61:0] ZC = 62'h19C3522FB386A45F;

  logic clk;
  logic nReset;

  logic        startA, readyA, validA, busyA, doneA;
  logic [15:0] keyA [3:0];
  logic [15:0] outA;
  logic [4:0]  idxA;

  logic        startB, readyB, validB, busyB, doneB;
  logic [23:0] keyB [2:0];
  logic [23:0] outB;
  logic [5:0]  idxB;

  logic        startC, readyC, validC, busyC, doneC;
  logic [15:0] keyC [1:0];
  logic [15:0] outC;
  logic [2:0]  idxC;

  logic [31:0] sched [64];
  int compared;
  int mismatched;

  simon_inverse_keyexpansion #(.N(16), .M(4), .T(32)) dutA (
    .clk(clk), .nReset(nReset), .start(startA), .key_last(keyA),
    .key_out(outA), .key_idx(idxA), .key_valid(validA), .key_ready(readyA),
    .busy(busyA), .done(doneA));

  simon_inverse_keyexpansion #(.N(24), .M(3), .T(36)) dutB (
    .clk(clk), .nReset(nReset), .start(startB), .key_last(keyB),
    .key_out(outB), .key_idx(idxB), .key_valid(validB), .key_ready(readyB),
    .busy(busyB), .done(doneB));

  simon_inverse_keyexpansion #(.N(16), .M(2), .T(8)) dutC (
    .clk(clk), .nReset(nReset), .start(startC), .key_last(keyC),
    .key_out(outC), .key_idx(idxC), .key_valid(validC), .key_ready(readyC),
    .busy(busyC), .done(doneC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rorN(input logic [31:0] x, input int s, input int n);
    logic [31:0] mask;
    mask = (32'h1 << n) - 32'h1;
    return ((x >> s) | (x << (n - s))) & mask;
  endfunction

  // Forward SIMON expansion from k[0..m-1]; the DUT must reproduce it backwards.
  task automatic buildSched(input int n, input int m, input int t,
                            input logic [31:0] s0, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] s3);
    logic [31:0] mask;
    logic [31:0] tmp;
    mask = (32'h1 << n) - 32'h1;
    sched[0] = s0 & mask;
    sched[1] = s1 & mask;
    sched[2] = s2 & mask;
    sched[3] = s3 & mask;
    for (int i = 0; i + m < t; i++) begin
      tmp = rorN(sched[i+m-1], 3, n);
      if (m == 4) tmp = tmp ^ sched[i+1];
      tmp = tmp ^ rorN(tmp, 1, n);
      sched[i+m] = (mask ^ 32'd3) ^ {31'd0, ZC[i % 62]} ^ sched[i] ^ tmp;
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    #2;
    compared++;
    if ({validA, busyA, doneA} !== 3'b000 || outA !== 16'h0 || idxA !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_A: got valid/busy/done=%b key=%h idx=%0d, need 000 key=0000 idx=0",
               {validA, busyA, doneA}, outA, idxA);
    end
    compared++;
    if ({validB, doneB, validC, doneC} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_BC: got validB/doneB/validC/doneC=%b, need 0000",
               {validB, doneB, validC, doneC});
    end
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkDoneA(input string tag);
    compared++;
    if ({doneA, validA, busyA} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL %s_done: got done/valid/busy=%b, need 100", tag, {doneA, validA, busyA});
    end
  endtask

  task automatic test_full_stream;
    readyA = 1'b1;
    for (int j = 0; j < 4; j++) keyA[j] = sched[28+j][15:0];
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int e = 31; e >= 0; e--) begin
      compared++;
      if (validA !== 1'b1 || busyA !== 1'b1 || idxA !== e[4:0] || outA !== sched[e][15:0]) begin
        mismatched++;
        $display("[TB] FAIL full_stream: got valid=%b busy=%b idx=%0d key=%h, need 1 1 idx=%0d key=%h",
                 validA, busyA, idxA, outA, e, sched[e][15:0]);
      end
      if (e == 0) begin
        compared++;
        if (outA !== 16'h0100) begin
          mismatched++;
          $display("[TB] FAIL last_key: got %h, need 0100", outA);
        end
      end
      @(negedge clk);
    end
    checkDoneA("full_stream");
  endtask

  task automatic test_backpressure;
    int e;
    int cyc;
    e = 31;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (cyc = 0; cyc < 400 && e >= 0; cyc++) begin
      compared++;
      if (validA !== 1'b1 || idxA !== e[4:0] || outA !== sched[e][15:0]) begin
        mismatched++;
        $display("[TB] FAIL backpressure: got valid=%b idx=%0d key=%h, need 1 idx=%0d key=%h",
                 validA, idxA, outA, e, sched[e][15:0]);
      end
      readyA = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (readyA) e--;
    end
    if (e >= 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL backpressure_timeout: got %0d keys left, need 0", e + 1);
    end
    readyA = 1'b1;
    checkDoneA("backpressure");
  endtask

  task automatic test_start_ignored;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int e = 31; e >= 0; e--) begin
      compared++;
      if (validA !== 1'b1 || idxA !== e[4:0] || outA !== sched[e][15:0]) begin
        mismatched++;
        $display("[TB] FAIL start_ignored: got valid=%b idx=%0d key=%h, need 1 idx=%0d key=%h",
                 validA, idxA, outA, e, sched[e][15:0]);
      end
      startA = (e == 20);
      @(negedge clk);
    end
    startA = 1'b0;
    checkDoneA("start_ignored");
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    compared++;
    if (validA !== 1'b1 || idxA !== 5'd31 || outA !== sched[31][15:0]) begin
      mismatched++;
      $display("[TB] FAIL restart_from_done: got valid=%b idx=%0d key=%h, need 1 idx=31 key=%h",
               validA, idxA, outA, sched[31][15:0]);
    end
  endtask

  task automatic test_midstream_reset;
    for (int e = 31; e >= 15; e--) begin
      compared++;
      if (validA !== 1'b1 || idxA !== e[4:0] || outA !== sched[e][15:0]) begin
        mismatched++;
        $display("[TB] FAIL pre_reset: got valid=%b idx=%0d key=%h, need 1 idx=%0d key=%h",
                 validA, idxA, outA, e, sched[e][15:0]);
      end
      if (e > 15) @(negedge clk);
    end
    #2;
    nReset = 1'b0;
    #1;
    compared++;
    if ({validA, busyA, doneA} !== 3'b000 || idxA !== 5'd0 || outA !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got valid/busy/done=%b idx=%0d key=%h, need 000 idx=0 key=0000",
               {validA, busyA, doneA}, idxA, outA);
    end
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    compared++;
    if ({validA, busyA, doneA} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got valid/busy/done=%b, need 000", {validA, busyA, doneA});
    end
    test_full_stream();
  endtask

  task automatic test_m3_n24;
    buildSched(24, 3, 36, $urandom, $urandom, $urandom, 32'd0);
    for (int j = 0; j < 3; j++) keyB[j] = sched[33+j][23:0];
    readyB = 1'b1;
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    for (int e = 35; e >= 0; e--) begin
      compared++;
      if (validB !== 1'b1 || idxB !== e[5:0] || outB !== sched[e][23:0]) begin
        mismatched++;
        $display("[TB] FAIL m3_n24: got valid=%b idx=%0d key=%h, need 1 idx=%0d key=%h",
                 validB, idxB, outB, e, sched[e][23:0]);
      end
      @(negedge clk);
    end
    compared++;
    if ({doneB, validB, busyB} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL m3_n24_done: got done/valid/busy=%b, need 100", {doneB, validB, busyB});
    end
  endtask

  task automatic test_m2_t8;
    buildSched(16, 2, 8, 32'h1234, 32'hBEEF, 32'd0, 32'd0);
    for (int j = 0; j < 2; j++) keyC[j] = sched[6+j][15:0];
    readyC = 1'b1;
    startC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    for (int e = 7; e >= 0; e--) begin
      compared++;
      if (validC !== 1'b1 || idxC !== e[2:0] || outC !== sched[e][15:0]) begin
        mismatched++;
        $display("[TB] FAIL m2_t8: got valid=%b idx=%0d key=%h, need 1 idx=%0d key=%h",
                 validC, idxC, outC, e, sched[e][15:0]);
      end
      @(negedge clk);
    end
    compared++;
    if ({doneC, validC, busyC} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL m2_t8_done: got done/valid/busy=%b, need 100", {doneC, validC, busyC});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nReset = 1'b1;
    startA = 1'b0; readyA = 1'b0;
    startB = 1'b0; readyB = 1'b0;
    startC = 1'b0; readyC = 1'b0;
    for (int j = 0; j < 4; j++) keyA[j] = '0;
    for (int j = 0; j < 3; j++) keyB[j] = '0;
    for (int j = 0; j < 2; j++) keyC[j] = '0;
    #1;
    test_reset();
    buildSched(16, 4, 32, 32'h0100, 32'h0908, 32'h1110, 32'h1918);
    test_full_stream();
    test_backpressure();
    test_start_ignored();
    test_midstream_reset();
    test_m3_n24();
    test_m2_t8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
